// File: rtl/sbox_hpc2_scheduler_if.sv
// Bus bundle between the S-box scheduler, its requesters, the PRNG, the shared S-box
// and the result consumer. The scheduler uses the slave modport; the environment uses master.
interface sbox_hpc2_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FRESH_W = 102,
  parameter int unsigned ID_W    = 2
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][15:0] req_data;
  logic                     rnd_valid;
  logic                     rnd_ready;
  logic [FRESH_W-1:0]       rnd_data;
  logic [15:0]              sbox_si;
  logic [FRESH_W-1:0]       sbox_fresh;
  logic                     sbox_rst;
  logic                     sbox_synch;
  logic [15:0]              sbox_so;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [15:0]              rsp_data;
  logic                     rsp_err;

  modport slave (
    input  req_valid, req_data, rnd_valid, rnd_data, sbox_synch, sbox_so, rsp_ready,
    output req_ready, rnd_ready, sbox_si, sbox_fresh, sbox_rst, rsp_valid, rsp_id,
           rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_data, rnd_valid, rnd_data, sbox_synch, sbox_so, rsp_ready,
    input  req_ready, rnd_ready, sbox_si, sbox_fresh, sbox_rst, rsp_valid, rsp_id,
           rsp_data, rsp_err
  );
endinterface

// File: rtl/sbox_hpc2_scheduler.sv
// Round-robin scheduler sharing one masked third-order HPC2 S-box among NUM_REQ requesters.
// Optional RUN-state watchdog: define SBOX_SCHED_WATCHDOG_EN.
module sbox_hpc2_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned FRESH_W = 102,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sbox_hpc2_scheduler_if.slave bus,
  output logic                 busy_o
);
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SH_W  = 16;
`ifdef SBOX_SCHED_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(LATENCY + 3);
`endif

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESP} state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   rr_ptr_q;
  logic [SH_W-1:0]    si_lat_q;
  logic [SH_W-1:0]    sbox_si_q;
  logic [FRESH_W-1:0] sbox_fresh_q;
  logic               sbox_rst_q;
  logic               rnd_ready_q;
  logic               rsp_valid_q;
  logic [SH_W-1:0]    rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               busy_q;
`ifdef SBOX_SCHED_WATCHDOG_EN
  logic [CNT_W-1:0]   run_cnt_q;
  logic               rsp_err_q;
`endif

  logic [NUM_REQ-1:0] gnt_c;
  logic [SEL_W-1:0]   gnt_idx_c;
  logic               gnt_vld_c;

  // Round-robin pick: first pending requester after the last grant, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    if (state_q == IDLE) begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        idx = (32'(rr_ptr_q) + off) % NUM_REQ;
        if (!gnt_vld_c && bus.req_valid[SEL_W'(idx)]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = SEL_W'(idx);
        end
      end
    end
    gnt_c = NUM_REQ'(gnt_vld_c) << gnt_idx_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= SEL_W'(NUM_REQ - 1);
      si_lat_q     <= '0;
      sbox_si_q    <= '0;
      sbox_fresh_q <= '0;
      sbox_rst_q   <= 1'b1;
      rnd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      busy_q       <= 1'b0;
`ifdef SBOX_SCHED_WATCHDOG_EN
      run_cnt_q    <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_vld_c) begin
            state_q     <= LOAD;
            rr_ptr_q    <= gnt_idx_c;
            si_lat_q    <= bus.req_data[gnt_idx_c];
            rnd_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          // Shares and randomness reach the S-box together, with its gating controller released.
          if (bus.rnd_valid) begin
            state_q      <= RUN;
            rnd_ready_q  <= 1'b0;
            sbox_si_q    <= si_lat_q;
            sbox_fresh_q <= bus.rnd_data;
            sbox_rst_q   <= 1'b0;
`ifdef SBOX_SCHED_WATCHDOG_EN
            run_cnt_q    <= '0;
`endif
          end
        end
        RUN: begin
          if (bus.sbox_synch) begin
            state_q    <= DRAIN;
            sbox_rst_q <= 1'b1;
          end
`ifdef SBOX_SCHED_WATCHDOG_EN
          else if (run_cnt_q == CNT_W'(LATENCY + 1)) begin
            // No Synch after LATENCY+2 cycles: give up and report an error with no data.
            state_q      <= RESP;
            sbox_rst_q   <= 1'b1;
            sbox_si_q    <= '0;
            sbox_fresh_q <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_id_q     <= ID_W'(rr_ptr_q);
            rsp_err_q    <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
`endif
        end
        DRAIN: begin
          state_q      <= RESP;
          rsp_data_q   <= bus.sbox_so;
          rsp_id_q     <= ID_W'(rr_ptr_q);
          rsp_valid_q  <= 1'b1;
          sbox_si_q    <= '0;
          sbox_fresh_q <= '0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
`ifdef SBOX_SCHED_WATCHDOG_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = gnt_c;
  assign bus.rnd_ready  = rnd_ready_q;
  assign bus.sbox_si    = sbox_si_q;
  assign bus.sbox_fresh = sbox_fresh_q;
  assign bus.sbox_rst   = sbox_rst_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
`ifdef SBOX_SCHED_WATCHDOG_EN
  assign bus.rsp_err    = rsp_err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_sbox_hpc2_scheduler.sv
// Self-checking bench for sbox_hpc2_scheduler: behavioural masked SKINNY S-box, directed
// vector table, corner-case sequences and a randomized run against a round-robin model.
module tb_sbox_hpc2_scheduler;
  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 8;
  localparam int unsigned FW  = 102;
  localparam int unsigned IW  = 2;
  localparam int unsigned SW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  sbox_hpc2_scheduler_if #(.NUM_REQ(NR), .FRESH_W(FW), .ID_W(IW)) bus ();

  sbox_hpc2_scheduler #(.NUM_REQ(NR), .LATENCY(LAT), .FRESH_W(FW), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] skinny(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
      4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
      4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
      4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] xor4(input logic [15:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8] ^ s[15:12];
  endfunction

  // Masked S-box: unmask, substitute, remask with three nibbles of the fresh word.
  function automatic logic [15:0] sbox_model(input logic [15:0] si, input logic [FW-1:0] fr);
    logic [3:0] y;
    y = skinny(xor4(si));
    return {y ^ fr[3:0] ^ fr[7:4] ^ fr[11:8], fr[11:8], fr[7:4], fr[3:0]};
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    return NR'(1) << i;
  endfunction

  function automatic int next_grant(input int last, input logic [NR-1:0] mask);
    for (int off = 1; off <= int'(NR); off++) begin
      if (((mask >> ((last + off) % NR)) & NR'(1)) != '0) return (last + off) % NR;
    end
    return -1;
  endfunction

  function automatic logic [FW-1:0] rand_fresh();
    return FW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // S-box timing model: Synch in the LATENCY-th cycle after its gating reset is released.
  int sb_cnt = 0;
  bit synch_stuck = 1'b0;
  always @(posedge clk) sb_cnt <= bus.sbox_rst ? 0 : sb_cnt + 1;
  assign bus.sbox_synch = !synch_stuck && !bus.sbox_rst && (sb_cnt == int'(LAT) - 1);
  assign bus.sbox_so    = sbox_model(bus.sbox_si, bus.sbox_fresh);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    bus.rnd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_state", 128'({busy, bus.sbox_rst, bus.rsp_valid, bus.rnd_ready, |bus.req_ready,
                             |bus.sbox_si, |bus.sbox_fresh, |bus.rsp_data, |bus.rsp_id,
                             bus.rsp_err}), 128'(10'b0100000000));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One evaluation: optional random-word stall, optional consumer stall with other requests
  // pending during RESP, then the post-handshake state and re-grant.
  task automatic run_txn(input string nm, input int id, input logic [15:0] sh,
                         input logic [3:0] exp_x, input int rnd_dly, input int rsp_dly,
                         input logic [NR-1:0] others);
    logic [FW-1:0] fr;
    logic [15:0]   held;
    int            n;
    int            ng;
    bit            seen;
    fr = rand_fresh();
    @(negedge clk);
    bus.req_valid = onehot(id);
    bus.req_data[SW'(id)] = sh;
    bus.rnd_data  = fr;
    bus.rnd_valid = (rnd_dly == 0);
    bus.rsp_ready = 1'b0;
    #1;
    chk({nm, ".grant"}, 128'(bus.req_ready), 128'(onehot(id)));
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      bus.req_valid = '0;
      bus.rnd_valid = (n > rnd_dly);
      #1;
      if (n <= rnd_dly)
        chk({nm, ".load_wait"}, 128'({bus.rnd_ready, bus.sbox_rst, busy, |bus.sbox_fresh,
                                       |bus.sbox_si}), 128'(5'b11100));
      seen = bus.rsp_valid;
    end
    chk({nm, ".latency"}, 128'(n - 1), 128'(2 + LAT + rnd_dly));
    chk({nm, ".id"}, 128'(bus.rsp_id), 128'(id));
    chk({nm, ".err"}, 128'(bus.rsp_err), 128'(0));
    chk({nm, ".shares"}, 128'(bus.rsp_data), 128'(sbox_model(sh, fr)));
    chk({nm, ".unmasked"}, 128'(xor4(bus.rsp_data)), 128'(exp_x));
    chk({nm, ".si_zero_resp"}, 128'({bus.sbox_si, |bus.sbox_fresh}), 128'(0));
    held = bus.rsp_data;
    for (int k = 0; k < rsp_dly; k++) begin
      @(negedge clk);
      bus.req_valid = others;
      #1;
      chk({nm, ".hold"}, 128'({bus.rsp_valid, bus.rsp_data, bus.req_ready}),
          128'({1'b1, held, NR'(0)}));
    end
    @(negedge clk);
    bus.req_valid = others;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk({nm, ".post"}, 128'({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err,
                             bus.sbox_si, busy}), 128'(0));
    ng = next_grant(id, others);
    chk({nm, ".regrant"}, 128'(bus.req_ready), 128'((ng < 0) ? NR'(0) : onehot(ng)));
    #1;
    bus.req_valid = '0;
  endtask

  typedef struct {
    int            id;
    logic [15:0]   sh;
    logic [3:0]    x;
    int            rnd_dly;
    int            rsp_dly;
    logic [NR-1:0] others;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int            n;
    bit            seen;
    int            gid [5];
    int            gcyc [5];
    int            rid [4];
    int            gcnt;
    int            rcnt;
    logic [NR-1:0] pend;
    logic [15:0]   pdat [NR];
    int            last;
    int            ng;
    int            resp_cnt;
    int            q_id [$];
    logic [15:0]   q_dat [$];
    logic [FW-1:0] cur_fresh;

    tbl[0] = '{2, 16'h5A5A, 4'hC, 0, 0, 4'b0000};
    tbl[1] = '{0, 16'h0001, 4'h6, 0, 0, 4'b0000};
    tbl[2] = '{1, 16'h1234, 4'h1, 5, 0, 4'b0000};
    tbl[3] = '{3, 16'hFFF0, 4'hF, 0, 10, 4'b0111};
    tbl[4] = '{0, 16'h8000, 4'h3, 2, 3, 4'b1000};
    tbl[5] = '{2, 16'h7777, 4'hC, 1, 1, 4'b0011};
    tbl[6] = '{1, 16'hA5C2, 4'h6, 0, 0, 4'b0101};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = '0;
    bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_reset();

    for (int v = 0; v < 7; v++)
      run_txn($sformatf("vec%0d", v), tbl[v].id, tbl[v].sh, tbl[v].x, tbl[v].rnd_dly,
              tbl[v].rsp_dly, tbl[v].others);

    // All requesters pending continuously: strict rotation at LATENCY+4 spacing.
    do_reset();
    for (int i = 0; i < 5; i++) begin gid[i] = -1; gcyc[i] = -100; end
    for (int i = 0; i < 4; i++) rid[i] = -1;
    gcnt = 0;
    rcnt = 0;
    @(negedge clk);
    bus.req_valid = '1;
    for (int i = 0; i < int'(NR); i++) bus.req_data[SW'(i)] = 16'($urandom());
    bus.rnd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 120 && gcnt < 5; c++) begin
      #1;
      for (int i = 0; i < int'(NR); i++)
        if (((bus.req_ready >> i) & NR'(1)) != '0) begin gid[gcnt] = i; gcyc[gcnt] = c; gcnt++; end
      if (bus.rsp_valid && bus.rsp_ready && rcnt < 4) begin rid[rcnt] = int'(bus.rsp_id); rcnt++; end
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) chk($sformatf("rr.grant%0d", k), 128'(gid[k]), 128'(k % NR));
    for (int k = 1; k < 5; k++) chk($sformatf("rr.gap%0d", k), 128'(gcyc[k] - gcyc[k-1]), 128'(LAT + 4));
    for (int k = 0; k < 4; k++) chk($sformatf("rr.rspid%0d", k), 128'(rid[k]), 128'(k % NR));
    bus.req_valid = '0;

    // Reset in RUN cycle 4 drops the evaluation.
    do_reset();
    @(negedge clk);
    bus.req_valid = onehot(1);
    bus.req_data[SW'(1)] = 16'h3C5A;
    bus.rnd_data = rand_fresh();
    bus.rnd_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin @(negedge clk); bus.req_valid = '0; end
    #1;
    chk("rst_mid.in_run", 128'({bus.sbox_rst, busy}), 128'(2'b01));
    rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", 128'({busy, bus.sbox_rst, bus.rsp_valid, bus.rnd_ready,
                                 |bus.sbox_si, |bus.sbox_fresh, |bus.rsp_data}), 128'(7'b0100000));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); #1; seen = seen | bus.rsp_valid; end
    chk("rst_mid.no_rsp", 128'(seen), 128'(0));
    run_txn("rst_recover", 0, 16'h1111, 4'hC, 0, 0, 4'b0000);

    // S-box never signals Synch.
    do_reset();
    synch_stuck = 1'b1;
    @(negedge clk);
    bus.req_valid = onehot(3);
    bus.req_data[SW'(3)] = 16'h9ABC;
    bus.rnd_data = rand_fresh();
    bus.rnd_valid = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      bus.req_valid = '0;
      #1;
      seen = bus.rsp_valid;
    end
`ifdef SBOX_SCHED_WATCHDOG_EN
    chk("wdog.latency", 128'(n - 1), 128'(LAT + 3));
    chk("wdog.resp", 128'({bus.rsp_err, bus.rsp_data, bus.rsp_id}), 128'({1'b1, 16'h0000, 2'd3}));
`else
    chk("wdog.stuck", 128'({seen, busy}), 128'(2'b01));
`endif
    synch_stuck = 1'b0;
    do_reset();

    // Randomized traffic against a transaction-level round-robin model.
    pend = '0;
    last = NR - 1;
    resp_cnt = 0;
    cur_fresh = '0;
    for (int i = 0; i < int'(NR); i++) pdat[i] = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < int'(NR); i++)
        if (((pend >> i) & NR'(1)) == '0 && $urandom_range(3) == 0) begin
          pend = pend | onehot(i);
          pdat[i] = 16'($urandom());
        end
      bus.req_valid = pend;
      for (int i = 0; i < int'(NR); i++) bus.req_data[SW'(i)] = pdat[i];
      bus.rnd_valid = ($urandom_range(2) != 0);
      bus.rnd_data  = rand_fresh();
      bus.rsp_ready = 1'($urandom_range(1));
      #1;
      if (bus.req_ready != '0) begin
        ng = next_grant(last, pend);
        chk("rand.grant", 128'(bus.req_ready), 128'((ng < 0) ? NR'(0) : onehot(ng)));
        chk("rand.one_outstanding", 128'(q_id.size()), 128'(0));
        if (ng >= 0) begin
          pend = pend & ~onehot(ng);
          last = ng;
          q_id.push_back(ng);
          q_dat.push_back(pdat[ng]);
        end
      end
      if (bus.rnd_ready && bus.rnd_valid) cur_fresh = bus.rnd_data;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q_id.size() == 0) begin
          chk("rand.spurious_rsp", 128'(1), 128'(0));
        end else begin
          chk("rand.rsp_id", 128'(bus.rsp_id), 128'(q_id[0]));
          chk("rand.rsp_data", 128'(bus.rsp_data), 128'(sbox_model(q_dat[0], cur_fresh)));
          void'(q_id.pop_front());
          void'(q_dat.pop_front());
          resp_cnt++;
        end
      end
    end
    chk("rand.progress", 128'(resp_cnt >= 20), 128'(1));
    bus.req_valid = '0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
